mem_resp_model: RTL and testbench

Synthesizable main-memory responder for the shared-bus side of the multicore cache system. It sits below `top` on the `mem_req_*` / `mem_resp_*` interface and completes the handshake the cache hierarchy initiates. Requests are buffered in an in-order queue and serviced one at a time after a fixed latency. Line storage has per-line valid tracking, so unwritten lines return a deterministic pattern.

---
 rtl/mem_resp_model_if.sv | 23 ++
 rtl/mem_resp_model.sv | 157 +++++++++++++++
 tb/tb_mem_resp_model.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_resp_model_if.sv
// Memory request/response bus between the cache hierarchy (master) and main memory (slave).
interface mem_resp_model_if #(
  parameter int ADDR_W = 26,   // ADDR_BITS - OFFSET_BITS
  parameter int LINE_W = 512   // CACHELINE_BITS
);
  logic              mem_req_valid;
  logic              mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [LINE_W-1:0] mem_req_data;
  logic              mem_req_ready;
  logic              mem_resp_valid;
  logic [LINE_W-1:0] mem_resp_data;

  modport master (
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/mem_resp_model.sv
// Main-memory responder: in-order request queue, fixed-latency service engine,
// line storage with per-line valid bits (unwritten lines read back their address).
module mem_resp_model #(
  parameter int ADDR_W    = 26,   // ADDR_BITS - OFFSET_BITS
  parameter int LINE_W    = 512,  // CACHELINE_BITS
  parameter int DEPTH     = 256,
  parameter int QDEPTH    = 4,
  parameter int LATENCY   = 4,
  parameter bit WRITE_ACK = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_resp_model_if.slave   bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int QC_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } req_t;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  req_t              fifo_q [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [QC_W-1:0]   count_q;
  logic              ready_en_q;
  logic              push, pop, exec;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              cur_q;

  logic [LINE_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [IDX_W-1:0]  cur_idx;

  // Ready is forced low combinationally while reset is held, and only rises
  // once reset_n has been sampled high.
  assign bus.mem_req_ready = reset_n && ready_en_q && (count_q != QC_W'(QDEPTH));
  assign push    = bus.mem_req_valid && bus.mem_req_ready;
  assign cur_idx = cur_q.addr[IDX_W-1:0];

  // Ready enable: set on the first edge that sees reset released.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) ready_en_q <= 1'b0;
    else          ready_en_q <= 1'b1;
  end

  // Queue storage: written at the tail on acceptance.
  // NOTE: storage arrays are not reset; pointers/count and valid bits say what is meaningful.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{rw: bus.mem_req_rw, addr: bus.mem_req_addr, data: bus.mem_req_data};
  end

  // Queue pointers and occupancy; pointers wrap naturally at QDEPTH.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + QC_W'(1);
        2'b01:   count_q <= count_q - QC_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Engine state and latency counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Engine next state: pop head when idle, count down, execute at zero and
  // pop the next head on the same edge so back-to-back service is LATENCY apart.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    exec    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          exec = 1'b1;
          if (count_q != '0) begin
            pop   = 1'b1;
            cnt_d = CNT_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request currently in service, loaded from the queue head on each pop.
  always_ff @(posedge clk) begin
    if (pop) cur_q <= fifo_q[rd_ptr_q];
  end

  // Line storage write; a reset edge drops the in-flight request.
  always_ff @(posedge clk) begin
    if (reset_n && exec && cur_q.rw) mem_q[cur_idx] <= cur_q.data;
  end

  // Valid tracking and the one-cycle response pulse; data holds after the pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_q              <= '0;
      bus.mem_resp_valid <= 1'b0;
      bus.mem_resp_data  <= '0;
    end else begin
      bus.mem_resp_valid <= 1'b0;
      if (exec) begin
        if (cur_q.rw) begin
          vld_q[cur_idx] <= 1'b1;
          if (WRITE_ACK) begin
            bus.mem_resp_valid <= 1'b1;
            bus.mem_resp_data  <= cur_q.data;
          end
        end else begin
          bus.mem_resp_valid <= 1'b1;
          bus.mem_resp_data  <= vld_q[cur_idx] ? mem_q[cur_idx] : LINE_W'(cur_q.addr);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_resp_model.sv
// Directed bench: three responders (LAT4/no write ack, LAT4/write ack, LAT1)
// share clock and reset; each is driven and observed independently.
module tb_mem_resp_model;

  localparam int AW = 16;
  localparam int LW = 64;

  typedef struct {
    int            edge_n;
    logic [LW-1:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // Edge counter: after edge N settles, cyc == N.
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]    req_valid, req_rw, rdy, rsp_valid;
  logic [AW-1:0] req_addr [3];
  logic [LW-1:0] req_data [3];
  logic [LW-1:0] rsp_data [3];

  resp_t rq0[$], rq1[$], rq2[$];

  mem_resp_model_if #(.ADDR_W(AW), .LINE_W(LW)) if0 (), if1 (), if2 ();

  mem_resp_model #(.ADDR_W(AW), .LINE_W(LW), .DEPTH(256), .QDEPTH(4), .LATENCY(4), .WRITE_ACK(1'b0))
    u_dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));
  mem_resp_model #(.ADDR_W(AW), .LINE_W(LW), .DEPTH(256), .QDEPTH(4), .LATENCY(4), .WRITE_ACK(1'b1))
    u_dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));
  mem_resp_model #(.ADDR_W(AW), .LINE_W(LW), .DEPTH(256), .QDEPTH(4), .LATENCY(1), .WRITE_ACK(1'b0))
    u_dut2 (.clk(clk), .reset_n(reset_n), .bus(if2));

  assign if0.mem_req_valid = req_valid[0];
  assign if0.mem_req_rw    = req_rw[0];
  assign if0.mem_req_addr  = req_addr[0];
  assign if0.mem_req_data  = req_data[0];
  assign if1.mem_req_valid = req_valid[1];
  assign if1.mem_req_rw    = req_rw[1];
  assign if1.mem_req_addr  = req_addr[1];
  assign if1.mem_req_data  = req_data[1];
  assign if2.mem_req_valid = req_valid[2];
  assign if2.mem_req_rw    = req_rw[2];
  assign if2.mem_req_addr  = req_addr[2];
  assign if2.mem_req_data  = req_data[2];

  assign rdy[0] = if0.mem_req_ready;
  assign rdy[1] = if1.mem_req_ready;
  assign rdy[2] = if2.mem_req_ready;
  assign rsp_valid[0] = if0.mem_resp_valid;
  assign rsp_valid[1] = if1.mem_resp_valid;
  assign rsp_valid[2] = if2.mem_resp_valid;
  assign rsp_data[0]  = if0.mem_resp_data;
  assign rsp_data[1]  = if1.mem_resp_data;
  assign rsp_data[2]  = if2.mem_resp_data;

  // Response monitor, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rsp_valid[0] === 1'b1) rq0.push_back('{edge_n: cyc, data: rsp_data[0]});
    if (rsp_valid[1] === 1'b1) rq1.push_back('{edge_n: cyc, data: rsp_data[1]});
    if (rsp_valid[2] === 1'b1) rq2.push_back('{edge_n: cyc, data: rsp_data[2]});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int n_resp(input int i);
    case (i)
      0:       return rq0.size();
      1:       return rq1.size();
      default: return rq2.size();
    endcase
  endfunction

  function automatic resp_t get_resp(input int i, input int j);
    resp_t r;
    r = '{edge_n: -1, data: '0};
    case (i)
      0:       if (j < rq0.size()) r = rq0[j];
      1:       if (j < rq1.size()) r = rq1[j];
      default: if (j < rq2.size()) r = rq2[j];
    endcase
    return r;
  endfunction

  task automatic clear_resp();
    rq0.delete();
    rq1.delete();
    rq2.delete();
  endtask

  // Called just after a falling edge: present a request, wait (bounded) for
  // ready, report the accepting edge and return at the following falling edge
  // with valid still asserted.
  task automatic send(input int i, input logic rw, input logic [AW-1:0] addr,
                      input logic [LW-1:0] data, output int acc);
    req_valid[i] = 1'b1;
    req_rw[i]    = rw;
    req_addr[i]  = addr;
    req_data[i]  = data;
    acc = -1;
    for (int n = 0; n < 40; n++) begin
      if (rdy[i] === 1'b1) begin
        acc = cyc + 1;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) check($sformatf("accept_timeout_dut%0d", i), rdy[i], 1'b1);
    @(negedge clk);
  endtask

  task automatic idle(input int i);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hard stop in case the stimulus itself hangs.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int    a0, a1;
    int    acc [8];
    resp_t r;

    req_valid = '0;
    req_rw    = '0;
    for (int i = 0; i < 3; i++) begin
      req_addr[i] = '0;
      req_data[i] = '0;
    end

    // Reset: ready low, response outputs cleared.
    reset_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        check($sformatf("rst_ready_dut%0d", i), rdy[i], 1'b0);
        check($sformatf("rst_resp_valid_dut%0d", i), rsp_valid[i], 1'b0);
        check($sformatf("rst_resp_data_dut%0d", i), rsp_data[i], 64'h0);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("ready_before_sampled_release", rdy[0], 1'b0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("ready_after_release_dut%0d", i), rdy[i], 1'b1);
    @(negedge clk);

    // Single read of an unwritten line: one pulse at accept+5 with the address pattern.
    clear_resp();
    send(0, 1'b0, 16'h002A, 64'h0, a0);
    idle(0);
    wait_cycles(12);
    check("single_read_count", n_resp(0), 1);
    r = get_resp(0, 0);
    check("single_read_edge", r.edge_n, a0 + 5);
    check("single_read_data", r.data, 64'h2A);

    // Write then read, no write ack: one response carrying the written data.
    clear_resp();
    send(0, 1'b1, 16'h0010, 64'hDEADBEEF, a0);
    send(0, 1'b0, 16'h0010, 64'h0, a1);
    idle(0);
    check("wr_rd_back_to_back_accept", a1, a0 + 1);
    wait_cycles(14);
    check("wr_rd_noack_count", n_resp(0), 1);
    r = get_resp(0, 0);
    check("wr_rd_noack_edge", r.edge_n, a0 + 9);
    check("wr_rd_noack_data", r.data, 64'hDEADBEEF);

    // Same with write ack: two pulses LATENCY apart, both with the written data.
    clear_resp();
    send(1, 1'b1, 16'h0010, 64'hDEADBEEF, a0);
    send(1, 1'b0, 16'h0010, 64'h0, a1);
    idle(1);
    wait_cycles(14);
    check("wr_rd_ack_count", n_resp(1), 2);
    r = get_resp(1, 0);
    check("wr_ack_edge", r.edge_n, a0 + 5);
    check("wr_ack_data", r.data, 64'hDEADBEEF);
    r = get_resp(1, 1);
    check("rd_after_ack_edge", r.edge_n, a0 + 9);
    check("rd_after_ack_data", r.data, 64'hDEADBEEF);

    // Eight streamed reads into a 4-deep queue: ready drops after 5 accepts,
    // responses in order, spaced LATENCY apart.
    clear_resp();
    for (int j = 0; j < 8; j++) begin
      send(0, 1'b0, AW'(16'h0040 + j), 64'h0, acc[j]);
      if (j == 4) check("full_ready_low", rdy[0], 1'b0);
    end
    idle(0);
    check("five_accepts_back_to_back", acc[4], acc[0] + 4);
    check("sixth_accept_after_pop", acc[5], acc[0] + 6);
    wait_cycles(40);
    check("stream_count", n_resp(0), 8);
    for (int j = 0; j < 8; j++) begin
      r = get_resp(0, j);
      check($sformatf("stream_data_%0d", j), r.data, 64'h40 + 64'(j));
      check($sformatf("stream_edge_%0d", j), r.edge_n, acc[0] + 5 + 4 * j);
    end

    // Aliasing: upper address bits ignored by the line index.
    clear_resp();
    send(0, 1'b1, 16'h0105, 64'h11, a0);
    send(0, 1'b0, 16'h0005, 64'h0, a1);
    idle(0);
    wait_cycles(14);
    check("alias_count", n_resp(0), 1);
    r = get_resp(0, 0);
    check("alias_data", r.data, 64'h11);

    // Reset mid-service: queued requests dropped, valid bits cleared.
    send(0, 1'b1, 16'h0020, 64'h77, a0);
    idle(0);
    wait_cycles(10);
    clear_resp();
    for (int j = 0; j < 4; j++) send(0, 1'b0, AW'(16'h0030 + j), 64'h0, acc[j]);
    idle(0);
    reset_n = 1'b0;
    #1;
    check("midrst_ready_low", rdy[0], 1'b0);
    wait_cycles(2);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready_after_release", rdy[0], 1'b1);
    @(negedge clk);
    wait_cycles(15);
    check("midrst_no_responses", n_resp(0), 0);
    send(0, 1'b0, 16'h0020, 64'h0, a0);
    idle(0);
    wait_cycles(10);
    check("midrst_read_count", n_resp(0), 1);
    r = get_resp(0, 0);
    check("midrst_read_pattern", r.data, 64'h20);

    // LATENCY=1: four back-to-back reads give four consecutive pulses from accept+2.
    clear_resp();
    for (int j = 0; j < 4; j++) send(2, 1'b0, AW'(16'h0050 + j), 64'h0, acc[j]);
    idle(2);
    check("lat1_accepts_back_to_back", acc[3], acc[0] + 3);
    wait_cycles(10);
    check("lat1_count", n_resp(2), 4);
    for (int j = 0; j < 4; j++) begin
      r = get_resp(2, j);
      check($sformatf("lat1_edge_%0d", j), r.edge_n, acc[0] + 2 + j);
      check($sformatf("lat1_data_%0d", j), r.data, 64'h50 + 64'(j));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
